cp0_ctrl: RTL

CP0_CTRL -- requirements
Module: cp0_ctrl

---
 rtl/cp0_ctrl_pkg.sv | 29 ++
 rtl/cp0_ctrl.sv | 80 ++++++++
 2 files changed

// File: rtl/cp0_ctrl_pkg.sv
// cp0_ctrl_pkg: register numbers, field positions and exception codes for the CP0 controller.
package cp0_ctrl_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int SR_IM_HI    = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    localparam logic [31:0] CP0_EXC_VECTOR = 32'h0000_4180;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS-style coprocessor 0 holding SR/Cause/EPC/PRId and raising interrupt/exception redirects.
module cp0_ctrl
    import cp0_ctrl_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0000_7001,
    parameter logic [31:0] EXC_VECTOR = CP0_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [31:0] VPC,
    input  logic        BD,
    input  logic [4:0]  ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);
    generate
        if (EXC_VECTOR[1:0] != 2'b00) begin : g_vec_chk
            $error("EXC_VECTOR must be word aligned");
        end
    endgenerate

    logic [5:0]  im, ip;
    logic        exl, ie, bd;
    logic [4:0]  exc;
    logic [31:0] epc, sr_word, cause_word;
    logic        int_pend, exc_pend;

    assign int_pend = |(HWInt & im) & ie & ~exl;
    assign exc_pend = (ExcCode != 5'd0) & ~exl;
    assign IntReq   = int_pend | exc_pend;
    assign EPC      = epc;

    assign sr_word    = {16'b0, im, 8'b0, exl, ie};
    assign cause_word = {bd, 15'b0, ip, 3'b0, exc, 2'b0};

    always_comb begin
        DOut = A1 == REG_SR    ? sr_word :
               A1 == REG_CAUSE ? cause_word :
               A1 == REG_EPC   ? epc :
               A1 == REG_PRID  ? PRID_VAL : 32'd0;
    end

    // Redirect takes precedence over mtc0 and eret; EXLClr is applied last so it beats an SR write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            im  <= '0;
            ip  <= '0;
            exl <= 1'b0;
            ie  <= 1'b0;
            bd  <= 1'b0;
            exc <= '0;
            epc <= '0;
        end else begin
            ip <= HWInt;
            if (IntReq) begin
                exl <= 1'b1;
                bd  <= BD;
                epc <= BD ? VPC - 32'd4 : VPC;
                exc <= int_pend ? EXC_INT : ExcCode;
            end else begin
                if (We && A2 == REG_SR) begin
                    im  <= DIn[SR_IM_HI:SR_IM_LO];
                    exl <= DIn[SR_EXL];
                    ie  <= DIn[SR_IE];
                end
                if (We && A2 == REG_EPC)
                    epc <= DIn;
                if (EXLClr)
                    exl <= 1'b0;
            end
        end
    end
endmodule
